row_copy_sched: RTL and testbench

Sequencer and arbiter for a signed ROWS×COLS×WIDTH array register file that supports whole-row copy (`XOUT[dst] = MEM[src]`). It shares one element write port between a host loader and two copy requesters. Each accepted copy is executed one column per cycle. The full array is exposed continuously on XOUT. It sits between control logic issuing row moves and downstream consumers of the 2-D array.

---
 rtl/row_copy_sched_if.sv | 35 +++
 rtl/row_copy_sched.sv | 174 +++++++++++++++++
 tb/tb_row_copy_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_copy_sched_if.sv
// Handshake and array-view bundle for row_copy_sched: host loader, two copy requesters, and XOUT.
interface row_copy_sched_if #(
  parameter int NROWS = 2,
  parameter int NCOLS = 2,
  parameter int WIDTH = 16,
  parameter int RW    = (NROWS > 1) ? $clog2(NROWS) : 1,
  parameter int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1
);
  logic                    ld_valid;
  logic [RW-1:0]           ld_row;
  logic [CW-1:0]           ld_col;
  logic signed [WIDTH-1:0] ld_data;
  logic                    ld_ready;

  logic [1:0]              req_valid;
  logic [RW-1:0]           req_src [2];
  logic [RW-1:0]           req_dst [2];
  logic [1:0]              req_ready;
  logic [1:0]              done;
  logic                    busy;

  logic signed [WIDTH-1:0] xout [NROWS][NCOLS];

  modport master (
    output ld_valid, ld_row, ld_col, ld_data,
    output req_valid, req_src, req_dst,
    input  ld_ready, req_ready, done, busy, xout
  );

  modport slave (
    input  ld_valid, ld_row, ld_col, ld_data,
    input  req_valid, req_src, req_dst,
    output ld_ready, req_ready, done, busy, xout
  );
endinterface

// File: rtl/row_copy_sched.sv
// Row-copy sequencer/arbiter over a ROWS x COLS signed register array with a shared element write port.
// Define ROW_COPY_SCHED_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module row_copy_sched #(
  parameter int NROWS = 2,
  parameter int NCOLS = 2,
  parameter int WIDTH = 16,
  parameter int RW    = (NROWS > 1) ? $clog2(NROWS) : 1,
  parameter int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  row_copy_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [RW-1:0]           r_src;
  logic [RW-1:0]           r_dst;
  logic                    r_owner;
  logic [CW-1:0]           r_col;
  logic signed [WIDTH-1:0] r_mem [NROWS][NCOLS];

  logic                    w_win;
  logic [1:0]              w_grant;
  logic                    w_accept;
  logic                    w_ld_fire;
  logic                    w_ld_ready;
  logic [1:0]              w_done;
  logic                    w_busy;
  logic                    w_last_col;
  logic                    w_src_ok;
  logic                    w_dst_ok;
  logic                    w_copy_we;
  logic signed [WIDTH-1:0] w_src_val;

  // w_win names the requester that takes the port if a request is accepted this cycle.
`ifdef ROW_COPY_SCHED_FIXED_PRIO_EN
  always_comb begin
    w_win = ~bus.req_valid[0];
  end
`else
  logic r_last;

  always_comb begin
    if (&bus.req_valid) begin
      w_win = ~r_last;
    end else begin
      w_win = bus.req_valid[1];
    end
  end

  // Reset value 1 makes requester 0 the favoured side of the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_win;
    end
  end
`endif

  assign w_last_col = (r_col == CW'(NCOLS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    w_ld_fire   = 1'b0;
    w_ld_ready  = 1'b0;
    w_done      = '0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ld_ready = 1'b1;
        if (bus.ld_valid) begin
          w_ld_fire = 1'b1;
        end else if (|bus.req_valid) begin
          w_grant     = w_win ? 2'b10 : 2'b01;
          w_state_nxt = S_COPY;
        end
      end
      S_COPY: begin
        w_busy = 1'b1;
        if (w_last_col) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_busy      = 1'b1;
        w_done      = r_owner ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept = |w_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_owner <= 1'b0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_src   <= bus.req_src[w_win];
        r_dst   <= bus.req_dst[w_win];
        r_owner <= w_win;
        r_col   <= '0;
      end else if (r_state == S_COPY) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Row range checks fall out of the row scan: an index with no matching row never enables a write.
  always_comb begin
    w_src_val = '0;
    w_src_ok  = 1'b0;
    w_dst_ok  = 1'b0;
    for (int unsigned r = 0; r < NROWS; r++) begin
      if (r_src == RW'(r)) begin
        w_src_ok = 1'b1;
        for (int unsigned c = 0; c < NCOLS; c++) begin
          if (r_col == CW'(c)) begin
            w_src_val = r_mem[r][c];
          end
        end
      end
      if (r_dst == RW'(r)) begin
        w_dst_ok = 1'b1;
      end
    end
  end

  assign w_copy_we = (r_state == S_COPY) && w_src_ok && w_dst_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        for (int unsigned c = 0; c < NCOLS; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        for (int unsigned c = 0; c < NCOLS; c++) begin
          if (w_ld_fire && bus.ld_row == RW'(r) && bus.ld_col == CW'(c)) begin
            r_mem[r][c] <= bus.ld_data;
          end else if (w_copy_we && r_dst == RW'(r) && r_col == CW'(c)) begin
            r_mem[r][c] <= w_src_val;
          end
        end
      end
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.req_ready = w_grant;
  assign bus.done      = w_done;
  assign bus.busy      = w_busy;
  assign bus.xout      = r_mem;

endmodule

// File: tb/tb_row_copy_sched.sv
// Self-checking bench for row_copy_sched: directed scenarios plus a randomized run against a timeline model.
module tb_row_copy_sched;
  localparam int NR  = 2;
  localparam int NC  = 2;
  localparam int W   = 16;
  localparam int RWB = 2;
  localparam int CWB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  row_copy_sched_if #(.NROWS(NR), .NCOLS(NC), .WIDTH(W), .RW(RWB), .CW(CWB)) bus ();

  row_copy_sched #(.NROWS(NR), .NCOLS(NC), .WIDTH(W), .RW(RWB), .CW(CWB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Model: phase 0 = idle, 1..NC = column phase-1 copied at the closing edge, NC+1 = completion cycle.
  logic signed [W-1:0] m_mem [NR][NC];
  int m_phase, m_src, m_dst, m_own, m_last;
  int n_cmp = 0;
  int n_err = 0;

  logic       obs_lr, exp_lr, obs_busy, exp_busy;
  logic [1:0] obs_rr, exp_rr, obs_done, exp_done;

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) m_mem[r][c] = '0;
    m_phase = 0;
    m_last  = 1;
  endtask

  task automatic set_idle();
    bus.ld_valid   = 1'b0;
    bus.ld_row     = '0;
    bus.ld_col     = '0;
    bus.ld_data    = '0;
    bus.req_valid  = 2'b00;
    bus.req_src[0] = '0;
    bus.req_dst[0] = '0;
    bus.req_src[1] = '0;
    bus.req_dst[1] = '0;
  endtask

  task automatic drive_load(input int row, input int col, input logic signed [W-1:0] val);
    bus.ld_valid = 1'b1;
    bus.ld_row   = RWB'(row);
    bus.ld_col   = CWB'(col);
    bus.ld_data  = val;
  endtask

  task automatic drive_req(input int who, input int src, input int dst);
    bus.req_valid[who] = 1'b1;
    bus.req_src[who]   = RWB'(src);
    bus.req_dst[who]   = RWB'(dst);
  endtask

  // One clock: capture DUT outputs mid-cycle, form expectations, then advance the model at the edge.
  task automatic tick();
    int win, lr, lc;
    #3;
    obs_lr   = bus.ld_ready;
    obs_rr   = bus.req_ready;
    obs_done = bus.done;
    obs_busy = bus.busy;
    exp_lr   = (m_phase == 0);
    exp_busy = (m_phase != 0);
    exp_done = (m_phase == NC + 1) ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
    exp_rr   = 2'b00;
    win      = -1;
    if (m_phase == 0 && !bus.ld_valid && bus.req_valid != 2'b00) begin
      if (bus.req_valid == 2'b11) begin
`ifdef ROW_COPY_SCHED_FIXED_PRIO_EN
        win = 0;
`else
        win = (m_last == 0) ? 1 : 0;
`endif
      end else begin
        win = bus.req_valid[1] ? 1 : 0;
      end
      exp_rr = (win == 1) ? 2'b10 : 2'b01;
    end
    @(posedge clk);
    if (m_phase == 0) begin
      if (bus.ld_valid) begin
        lr = int'(bus.ld_row);
        lc = int'(bus.ld_col);
        if (lr < NR && lc < NC) m_mem[lr][lc] = bus.ld_data;
      end else if (win >= 0) begin
        m_src   = int'(bus.req_src[win]);
        m_dst   = int'(bus.req_dst[win]);
        m_own   = win;
        m_last  = win;
        m_phase = 1;
      end
    end else if (m_phase <= NC) begin
      if (m_src < NR && m_dst < NR) m_mem[m_dst][m_phase-1] = m_mem[m_src][m_phase-1];
      m_phase++;
    end else begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (bus.xout[r][c] !== 16'sd0) begin
          n_err++;
          $display("FAIL reset_xout[%0d][%0d]: got %0h want 0", r, c, bus.xout[r][c]);
        end
      end
    n_cmp++;
    if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", bus.done); end
    n_cmp++;
    if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    int rows [4] = '{0, 0, 1, 1};
    int cols [4] = '{0, 1, 0, 1};
    logic signed [W-1:0] vals [4] = '{16'sh1234, -16'sd5, 16'sd7, 16'sd9};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      drive_load(rows[i], cols[i], vals[i]);
      tick();
      n_cmp++;
      if (obs_lr !== 1'b1) begin n_err++; $display("FAIL load_ld_ready[%0d]: got %b want 1", i, obs_lr); end
    end
    set_idle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.xout[rows[i]][cols[i]] !== vals[i]) begin
        n_err++;
        $display("FAIL load_xout[%0d][%0d]: got %0d want %0d", rows[i], cols[i], bus.xout[rows[i]][cols[i]], vals[i]);
      end
    end
  endtask

  task automatic test_copy();
    logic       busy_pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] done_pat [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    set_idle();
    drive_req(0, 0, 1);
    tick();
    n_cmp++;
    if (obs_rr !== 2'b01) begin n_err++; $display("FAIL copy_grant: got %b want 01", obs_rr); end
    set_idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (obs_busy !== busy_pat[k]) begin n_err++; $display("FAIL copy_busy[%0d]: got %b want %b", k, obs_busy, busy_pat[k]); end
      n_cmp++;
      if (obs_done !== done_pat[k]) begin n_err++; $display("FAIL copy_done[%0d]: got %b want %b", k, obs_done, done_pat[k]); end
    end
    n_cmp++;
    if (bus.xout[1][0] !== 16'sh1234 || bus.xout[1][1] !== -16'sd5) begin
      n_err++;
      $display("FAIL copy_row1: got {%0d,%0d} want {4660,-5}", bus.xout[1][0], bus.xout[1][1]);
    end
    n_cmp++;
    if (bus.xout[0][0] !== 16'sh1234 || bus.xout[0][1] !== -16'sd5) begin
      n_err++;
      $display("FAIL copy_row0: got {%0d,%0d} want {4660,-5}", bus.xout[0][0], bus.xout[0][1]);
    end
  endtask

  task automatic test_rr();
    logic [1:0] grants [$];
`ifdef ROW_COPY_SCHED_FIXED_PRIO_EN
    logic [1:0] want [3] = '{2'b01, 2'b01, 2'b01};
`else
    logic [1:0] want [3] = '{2'b01, 2'b10, 2'b01};
`endif
    set_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_req(0, 1, 0);
    drive_req(1, 0, 1);
    for (int k = 0; k < 3 * (NC + 2); k++) begin
      tick();
      n_cmp++;
      if (obs_rr !== exp_rr) begin n_err++; $display("FAIL rr_grant_cycle[%0d]: got %b want %b", k, obs_rr, exp_rr); end
      if (obs_rr != 2'b00) grants.push_back(obs_rr);
    end
    set_idle();
    n_cmp++;
    if (grants.size() != 3) begin
      n_err++;
      $display("FAIL rr_grant_count: got %0d want 3", grants.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (grants[i] !== want[i]) begin n_err++; $display("FAIL rr_seq[%0d]: got %b want %b", i, grants[i], want[i]); end
      end
    end
  endtask

  task automatic test_load_beats_req();
    set_idle();
    drive_load(1, 0, 16'sh0055);
    drive_req(1, 1, 0);
    tick();
    n_cmp++;
    if (obs_rr !== 2'b00) begin n_err++; $display("FAIL lbr_req_ready: got %b want 00", obs_rr); end
    n_cmp++;
    if (obs_lr !== 1'b1) begin n_err++; $display("FAIL lbr_ld_ready: got %b want 1", obs_lr); end
    n_cmp++;
    if (bus.xout[1][0] !== 16'sh0055) begin n_err++; $display("FAIL lbr_written: got %0h want 55", bus.xout[1][0]); end
    bus.ld_valid = 1'b0;
    tick();
    n_cmp++;
    if (obs_rr !== 2'b10) begin n_err++; $display("FAIL lbr_next_grant: got %b want 10", obs_rr); end
    set_idle();
    for (int k = 0; k < NC + 2; k++) begin
      tick();
      n_cmp++;
      if (obs_done !== exp_done) begin n_err++; $display("FAIL lbr_done[%0d]: got %b want %b", k, obs_done, exp_done); end
    end
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (bus.xout[r][c] !== m_mem[r][c]) begin
          n_err++;
          $display("FAIL lbr_xout[%0d][%0d]: got %0d want %0d", r, c, bus.xout[r][c], m_mem[r][c]);
        end
      end
  endtask

  task automatic test_reset_mid_copy();
    set_idle();
    drive_load(0, 0, 16'sh0A0A);
    tick();
    drive_load(0, 1, 16'sh0B0B);
    tick();
    set_idle();
    drive_req(0, 0, 1);
    tick();
    n_cmp++;
    if (obs_rr !== 2'b01) begin n_err++; $display("FAIL rmc_grant: got %b want 01", obs_rr); end
    set_idle();
    tick();
    n_cmp++;
    if (bus.xout[1][0] !== 16'sh0A0A) begin n_err++; $display("FAIL rmc_first_col: got %0h want a0a", bus.xout[1][0]); end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (bus.xout[r][c] !== 16'sd0) begin
          n_err++;
          $display("FAIL rmc_xout[%0d][%0d]: got %0h want 0", r, c, bus.xout[r][c]);
        end
      end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmc_busy: got %b want 0", bus.busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NC + 2; k++) begin
      tick();
      n_cmp++;
      if (obs_done !== 2'b00) begin n_err++; $display("FAIL rmc_no_done[%0d]: got %b want 00", k, obs_done); end
      n_cmp++;
      if (obs_lr !== 1'b1) begin n_err++; $display("FAIL rmc_ld_ready[%0d]: got %b want 1", k, obs_lr); end
    end
  endtask

  task automatic test_degenerate();
    int srcs [3] = '{1, 3, 0};
    int dsts [3] = '{1, 0, 3};
    logic signed [W-1:0] snap [NR][NC];
    int lat;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        set_idle();
        drive_load(r, c, W'($urandom_range(1, 16'h7FFF)));
        tick();
      end
    snap = m_mem;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      drive_req(i % 2, srcs[i], dsts[i]);
      tick();
      set_idle();
      lat = -1;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (obs_done != 2'b00) begin
          n_cmp++;
          if (obs_done !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL degen_owner[%0d]: got %b want %b", i, obs_done, (i % 2 == 1) ? 2'b10 : 2'b01);
          end
          lat = k;
          break;
        end
      end
      n_cmp++;
      if (lat != NC) begin n_err++; $display("FAIL degen_latency[%0d]: got %0d want %0d", i, lat, NC); end
      tick();
    end
    set_idle();
    drive_load(3, 0, 16'sh7777);
    tick();
    drive_load(0, 3, 16'sh6666);
    tick();
    n_cmp++;
    if (obs_lr !== 1'b1) begin n_err++; $display("FAIL degen_oor_ld_ready: got %b want 1", obs_lr); end
    set_idle();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (bus.xout[r][c] !== snap[r][c]) begin
          n_err++;
          $display("FAIL degen_xout[%0d][%0d]: got %0d want %0d", r, c, bus.xout[r][c], snap[r][c]);
        end
      end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      bus.ld_valid   = ($urandom_range(0, 9) < 3);
      bus.ld_row     = RWB'($urandom_range(0, 3));
      bus.ld_col     = CWB'($urandom_range(0, 3));
      bus.ld_data    = W'($urandom);
      bus.req_valid  = 2'($urandom_range(0, 3));
      bus.req_src[0] = RWB'($urandom_range(0, 3));
      bus.req_dst[0] = RWB'($urandom_range(0, 3));
      bus.req_src[1] = RWB'($urandom_range(0, 3));
      bus.req_dst[1] = RWB'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if (obs_lr !== exp_lr) begin n_err++; $display("FAIL rnd_ld_ready[%0d]: got %b want %b", k, obs_lr, exp_lr); end
      n_cmp++;
      if (obs_rr !== exp_rr) begin n_err++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", k, obs_rr, exp_rr); end
      n_cmp++;
      if (obs_done !== exp_done) begin n_err++; $display("FAIL rnd_done[%0d]: got %b want %b", k, obs_done, exp_done); end
      n_cmp++;
      if (obs_busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, obs_busy, exp_busy); end
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) begin
          n_cmp++;
          if (bus.xout[r][c] !== m_mem[r][c]) begin
            n_err++;
            $display("FAIL rnd_xout[%0d][%0d] cyc %0d: got %0d want %0d", r, c, k, bus.xout[r][c], m_mem[r][c]);
          end
        end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_copy();
    test_rr();
    test_load_beats_req();
    test_reset_mid_copy();
    test_degenerate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
